// File: rtl/simon_btn_decoder.sv
// Synchronises, debounces and one-hot-qualifies the four Simon buttons into one press code per physical press.
// Latency: press_valid rises DEBOUNCE_CYCLES+3 edges after btn goes stable; held with a stable code until press_ready.
module simon_btn_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       en,
    input  logic       press_ready,
    output logic       press_valid,
    output logic [1:0] press_code,
    output logic       multi_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_VALID,
        ST_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         cand_q, cand_d;
    logic [3:0]         btn_meta_q, btn_meta_d;
    logic [3:0]         btn_s_q, btn_s_d;
    logic               press_valid_q, press_valid_d;
    logic [1:0]         press_code_q, press_code_d;
    logic               multi_err_q, multi_err_d;
    logic [1:0]         cand_idx;

    always_comb begin
        case (cand_q)
            4'b0010: cand_idx = 2'd1;
            4'b0100: cand_idx = 2'd2;
            4'b1000: cand_idx = 2'd3;
            default: cand_idx = 2'd0;
        endcase
    end

    always_comb begin
        btn_meta_d    = btn;
        btn_s_d       = btn_meta_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        cand_d        = cand_q;
        press_valid_d = press_valid_q;
        press_code_d  = press_code_q;
        multi_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && (btn_s_q != 4'b0000)) begin
                    state_d = ST_ARM;
                    cand_d  = btn_s_q;
                    cnt_d   = '0;
                end
            end
            ST_ARM: begin
                if (btn_s_q == 4'b0000) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (btn_s_q != cand_q) begin
                    cand_d = btn_s_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // Chords are flagged and then treated like a consumed press.
                    if ($onehot(cand_q)) begin
                        state_d       = ST_VALID;
                        press_valid_d = 1'b1;
                        press_code_d  = cand_idx;
                    end else begin
                        state_d     = ST_RELEASE;
                        multi_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_VALID: begin
                if (press_valid_q && press_ready) begin
                    state_d       = ST_RELEASE;
                    press_valid_d = 1'b0;
                    cnt_d         = '0;
                end
            end
            ST_RELEASE: begin
                if (btn_s_q != 4'b0000) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RELEASE;
            cnt_q         <= '0;
            cand_q        <= 4'b0000;
            btn_meta_q    <= 4'b0000;
            btn_s_q       <= 4'b0000;
            press_valid_q <= 1'b0;
            press_code_q  <= 2'd0;
            multi_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            btn_meta_q    <= btn_meta_d;
            btn_s_q       <= btn_s_d;
            press_valid_q <= press_valid_d;
            press_code_q  <= press_code_d;
            multi_err_q   <= multi_err_d;
        end
    end

    assign press_valid = press_valid_q;
    assign press_code  = press_code_q;
    assign multi_err   = multi_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_simon_btn_decoder.sv
// Bench for simon_btn_decoder: directed press scenarios then random button traffic, all against a run-length model.
module tb_simon_btn_decoder;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       en;
    logic       press_ready;
    logic       press_valid;
    logic [1:0] press_code;
    logic       multi_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    simon_btn_decoder #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .en(en),
        .press_ready(press_ready),
        .press_valid(press_valid),
        .press_code(press_code),
        .multi_err(multi_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: phases described by run lengths of the synchronised samples.
    localparam int WAIT_QUIET = 0, LISTEN = 1, QUALIFY = 2, HOLD = 3;
    int         m_phase;
    int         quiet_run;
    int         same_run;
    logic [3:0] m_cand;
    logic [3:0] pipe1, pipe2;
    logic       m_valid;
    logic [1:0] m_code;
    logic       m_err;
    int         m_hs, dut_hs, dut_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] x;
        if (reset) begin
            m_phase = WAIT_QUIET; quiet_run = 0; same_run = 0; m_cand = 0;
            m_valid = 0; m_code = 0; m_err = 0; pipe1 = 0; pipe2 = 0;
            return;
        end
        x = pipe2;
        m_err = 0;
        case (m_phase)
            WAIT_QUIET: begin
                quiet_run = (x == 0) ? quiet_run + 1 : 0;
                if (quiet_run == D) m_phase = LISTEN;
            end
            LISTEN: if (en && x != 0) begin
                m_phase = QUALIFY; m_cand = x; same_run = 1;
            end
            QUALIFY: begin
                if (x == 0) m_phase = LISTEN;
                else if (x != m_cand) begin m_cand = x; same_run = 1; end
                else begin
                    same_run++;
                    if (same_run == D + 1) begin
                        if ($countones(m_cand) == 1) begin
                            m_phase = HOLD; m_valid = 1;
                            for (int i = 0; i < 4; i++) if (m_cand[i]) m_code = 2'(i);
                        end else begin
                            m_phase = WAIT_QUIET; quiet_run = 0; m_err = 1;
                        end
                    end
                end
            end
            default: if (press_ready) begin
                m_phase = WAIT_QUIET; quiet_run = 0; m_valid = 0; m_hs++;
            end
        endcase
        pipe2 = pipe1;
        pipe1 = btn;
    endtask

    task automatic step();
        if (press_valid && press_ready) dut_hs++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (multi_err) dut_err++;
        check("press_valid", 32'(press_valid), 32'(m_valid));
        check("press_code", 32'(press_code), 32'(m_code));
        check("multi_err", 32'(multi_err), 32'(m_err));
        check("busy", 32'(busy), 32'(m_phase != LISTEN));
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        btn = b;
        for (int i = 0; i < n; i++) step();
    endtask

    int first_vld, hs0, err0;
    logic [3:0] rb;

    initial begin
        reset = 1; btn = 0; en = 1; press_ready = 1;
        m_hs = 0; dut_hs = 0; dut_err = 0;
        m_phase = WAIT_QUIET; quiet_run = 0; same_run = 0; m_cand = 0;
        m_valid = 0; m_code = 0; m_err = 0; pipe1 = 0; pipe2 = 0;
        @(negedge clk);

        // 1: reset, settle, single press latency
        for (int i = 0; i < 3; i++) step();
        check("rst_valid", 32'(press_valid), 32'd0);
        check("rst_code", 32'(press_code), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        reset = 0;
        hold(4'b0000, 10);
        check("idle_busy", 32'(busy), 32'd0);
        hs0 = dut_hs;
        btn = 4'b0100; first_vld = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (press_valid && first_vld == 0) first_vld = i;
        end
        check("s1_latency", 32'(first_vld), 32'd11);
        check("s1_hs", 32'(dut_hs - hs0), 32'd1);
        hold(4'b0000, 12);

        // 2: bounce then stable press
        hs0 = dut_hs; err0 = dut_err;
        hold(4'b0001, 5); hold(4'b0000, 2); hold(4'b0001, 20); hold(4'b0000, 12);
        check("s2_hs", 32'(dut_hs - hs0), 32'd1);
        check("s2_err", 32'(dut_err - err0), 32'd0);

        // 3: chord flagged, then a clean press
        hs0 = dut_hs; err0 = dut_err;
        hold(4'b0011, 20); hold(4'b0000, 10);
        check("s3_err", 32'(dut_err - err0), 32'd1);
        check("s3_hs_chord", 32'(dut_hs - hs0), 32'd0);
        hold(4'b1000, 20); hold(4'b0000, 12);
        check("s3_hs", 32'(dut_hs - hs0), 32'd1);

        // 4: back-pressure holds code, extra press lost
        hs0 = dut_hs; press_ready = 0;
        hold(4'b0010, 20); hold(4'b0000, 50);
        check("s4_held_valid", 32'(press_valid), 32'd1);
        check("s4_held_code", 32'(press_code), 32'd1);
        hold(4'b0001, 20); hold(4'b0000, 15);
        check("s4_code_kept", 32'(press_code), 32'd1);
        press_ready = 1;
        step();
        check("s4_drop", 32'(press_valid), 32'd0);
        hold(4'b0000, 12);
        check("s4_hs", 32'(dut_hs - hs0), 32'd1);

        // 5: reset while arming with button held
        hs0 = dut_hs;
        hold(4'b0100, 5);
        reset = 1; step(); reset = 0;
        check("s5_busy", 32'(busy), 32'd1);
        hold(4'b0100, 20); hold(4'b0000, 12);
        check("s5_hs", 32'(dut_hs - hs0), 32'd0);

        // 6: disabled input
        hs0 = dut_hs; err0 = dut_err; en = 0;
        hold(4'b1000, 20); hold(4'b0000, 10);
        check("s6_hs", 32'(dut_hs - hs0), 32'd0);
        check("s6_err", 32'(dut_err - err0), 32'd0);
        check("s6_busy", 32'(busy), 32'd0);

        // random traffic
        for (int seg = 0; seg < 120; seg++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: rb = 4'(1 << $urandom_range(0, 3));
                6, 7:             rb = 4'($urandom_range(0, 15));
                default:          rb = 4'b0000;
            endcase
            en = ($urandom_range(0, 4) != 0);
            press_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 29) == 0) begin
                reset = 1; step(); reset = 0;
            end
            hold(rb, $urandom_range(1, 24));
        end
        press_ready = 1;
        hold(4'b0000, 12);
        check("total_hs", 32'(dut_hs), 32'(m_hs));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
